pixel_readout: RTL and testbench
================================

// Module: pixel_readout
// PURPOSE
//  Pixel-side responder to the DPS phase controller (erase/expose/convert/read1/read2) for a 2x2 digital pixel.
//  During convert it runs a shared ramp code counter and latches a per-pixel code on each comparator's first assertion.
//  During read1/read2 it presents row 0 / row 1 codes to the chip readout bus.
//  Phase inputs change on negedge clk; this block samples them on posedge clk.
// PARAMETERS
//  BITS     8    code width; counter saturates at 2**BITS-1
//  N_PIX    4    pixel count, fixed 2x2; index 0=r0c0, 1=r0c1, 2=r1c0, 3=r1c1
// PORTS
//  clk           in   1         clock, all state on posedge
//  reset         in   1         asynchronous, active-high reset
//  erase         in   1         erase phase from controller
//  expose        in   1         expose phase (no action here, used only for protocol check)
//  convert       in   1         convert phase, enables ramp counter and code capture
//  read1         in   1         read row 0 phase
//  read2         in   1         read row 1 phase
//  cmp           in   N_PIX     pixel comparator outputs, synchronous to clk
//  data_out      out  2*BITS    {col1 code, col0 code} of selected row
//  data_valid    out  1         one-cycle strobe, data_out updated this cycle
//  overflow      out  N_PIX     pixel did not fire during last convert
//  code_cnt      out  BITS      current ramp counter value (debug/DAC drive)
//  protocol_err  out  1         sticky: more than one phase input high in the same cycle
// BEHAVIOUR
//  Reset (async): code_cnt, all codes, fired flags, data_out, data_valid, overflow, protocol_err = 0.
//  Phase priority when several inputs are high: erase > convert > read1 > read2 > expose.
//   - Any such cycle sets protocol_err=1. It stays set until reset.
//  erase=1: codes = 0, fired = 0, overflow = 0, code_cnt = 0. data_out holds.
//  convert=1, each posedge:
//   - For each pixel i with fired[i]=0 and cmp[i]=1: code[i] <= code_cnt (pre-increment value), fired[i] <= 1.
//   - code_cnt <= code_cnt+1, saturating at 2**BITS-1 (no wrap).
//   - The first convert cycle captures code 0.
//   - Once fired, further cmp edges/glitches are ignored until the next erase.
//  convert falling (sampled 1 last cycle, 0 now):
//   - For each pixel with fired=0: code = all ones, overflow[i] = 1.
//   - code_cnt resets to 0.
//   - A pixel firing after saturation gets code all ones with overflow = 0.
//  read1 rising (sampled 0 last cycle, 1 now): next posedge data_out = {code[1],code[0]}, data_valid = 1.
//  read2 rising: next posedge data_out = {code[3],code[2]}, data_valid = 1.
//  Read latency is 1 cycle. data_valid is exactly one cycle per read phase, regardless of phase length.
//   - data_out holds until the next read.
//   - A read with no preceding convert returns stored codes (0 after erase/reset).
//  Convert re-entered without erase: fired flags persist.
//   - Only unfired pixels capture; the counter restarts at 0.
//  Reset mid-phase: immediate clear as above. Edge detectors clear, so a phase input still high after
//   reset release counts as a rising edge.
//  expose: no state change.
// TESTING
//  1 Assert reset mid-run -> all outputs 0 asynchronously, before next clk edge.
//  2 Capture and read: erase, then convert 256 cycles; cmp[2]=1 from start, cmp[0] rises at cnt 10, cmp[1] at cnt 200,
//    cmp[3] never rises.
//    -> read1: data_out=16'hC80A; read2: 16'hFF00; overflow=4'b1000.
//  3 cmp[0] high at cnt 10, low at 11, high again at 50 -> code[0]=10.
//  4 read1 held 5 cycles -> single data_valid pulse, 1 cycle after first sampled read1.
//  5 convert held 300 cycles, cmp[1] rises at cycle 280 -> code_cnt stops at 255; code[1]=255, overflow[1]=0.
//  6 erase and convert both high one cycle -> protocol_err=1 sticky, codes cleared (erase wins);
//    reset at cnt 100 mid-convert -> next convert captures from 0.

Source files
------------

// File: rtl/pixel_readout_if.sv
// rtl/pixel_readout_if.sv - phase, comparator and readout bus between controller and 2x2 pixel responder
interface pixel_readout_if #(
   parameter int BITS  = 8,
   parameter int N_PIX = 4
);
   logic                erase;
   logic                expose;
   logic                convert;
   logic                read1;
   logic                read2;
   logic [N_PIX-1:0]    cmp;
   logic [2*BITS-1:0]   data_out;
   logic                data_valid;
   logic [N_PIX-1:0]    overflow;
   logic [BITS-1:0]     code_cnt;
   logic                protocol_err;

   // controller / chip side: drives phases and comparators, observes readout
   modport master (
      output erase, expose, convert, read1, read2, cmp,
      input  data_out, data_valid, overflow, code_cnt, protocol_err
   );

   // pixel side
   modport slave (
      input  erase, expose, convert, read1, read2, cmp,
      output data_out, data_valid, overflow, code_cnt, protocol_err
   );
endinterface

// File: rtl/pixel_readout.sv
// rtl/pixel_readout.sv - 2x2 digital pixel responder: ramp code capture and row readout
module pixel_readout #(
   parameter int BITS  = 8,
   parameter int N_PIX = 4
) (
   input  logic           clk,
   input  logic           reset,
   pixel_readout_if.slave bus
);
   localparam logic [BITS-1:0] CODE_MAX = {BITS{1'b1}};

   // effective phase after priority resolution; the previous one drives edge detection
   typedef enum logic [2:0] {
      PH_IDLE,
      PH_ERASE,
      PH_EXPOSE,
      PH_CONVERT,
      PH_READ1,
      PH_READ2
   } phase_t;

   phase_t              phase_q;
   phase_t              phase_d;
   logic                do_erase;
   logic                do_convert;
   logic                convert_fall;
   logic                read1_rise;
   logic                read2_rise;
   logic                multi_phase;

   logic [BITS-1:0]     code_q [N_PIX];
   logic [N_PIX-1:0]    fired_q;
   logic [N_PIX-1:0]    overflow_q;
   logic [BITS-1:0]     cnt_q;
   logic [1:0]          read_pend_q;
   logic [2*BITS-1:0]   data_q;
   logic                valid_q;
   logic                err_q;

   // phase register; reset clears it so a phase still held after reset reads as a fresh edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q <= PH_IDLE;
      end else begin
         phase_q <= phase_d;
      end
   end

   // priority decode of the phase inputs and edge strobes against the previous phase
   always_comb begin
      phase_d      = PH_IDLE;
      do_erase     = 1'b0;
      do_convert   = 1'b0;
      convert_fall = 1'b0;
      read1_rise   = 1'b0;
      read2_rise   = 1'b0;
      multi_phase  = 1'b0;

      if (bus.erase) begin
         phase_d = PH_ERASE;
      end else if (bus.convert) begin
         phase_d = PH_CONVERT;
      end else if (bus.read1) begin
         phase_d = PH_READ1;
      end else if (bus.read2) begin
         phase_d = PH_READ2;
      end else if (bus.expose) begin
         phase_d = PH_EXPOSE;
      end

      multi_phase  = $countones({bus.erase, bus.expose, bus.convert, bus.read1, bus.read2}) > 1;
      do_erase     = (phase_d == PH_ERASE);
      do_convert   = (phase_d == PH_CONVERT);
      // an erase ending a convert clears everything, so the overflow fill is skipped
      convert_fall = (phase_q == PH_CONVERT) && !do_convert && !do_erase;
      read1_rise   = (phase_d == PH_READ1) && (phase_q != PH_READ1);
      read2_rise   = (phase_d == PH_READ2) && (phase_q != PH_READ2);
   end

   // per-pixel code capture on first comparator assertion, overflow fill when convert ends
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_PIX; i++) begin
            code_q[i] <= '0;
         end
         fired_q    <= '0;
         overflow_q <= '0;
      end else if (do_erase) begin
         for (int i = 0; i < N_PIX; i++) begin
            code_q[i] <= '0;
         end
         fired_q    <= '0;
         overflow_q <= '0;
      end else if (do_convert) begin
         for (int i = 0; i < N_PIX; i++) begin
            if (!fired_q[i] && bus.cmp[i]) begin
               code_q[i]  <= cnt_q;
               fired_q[i] <= 1'b1;
            end
         end
      end else if (convert_fall) begin
         for (int i = 0; i < N_PIX; i++) begin
            if (!fired_q[i]) begin
               code_q[i] <= CODE_MAX;
            end
         end
         // pixels that fired in a re-entered convert drop their earlier overflow
         overflow_q <= ~fired_q;
      end
   end

   // shared ramp counter: counts during convert, saturates, restarts when convert ends
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (do_erase) begin
         cnt_q <= '0;
      end else if (do_convert) begin
         if (cnt_q != CODE_MAX) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end else if (convert_fall) begin
         cnt_q <= '0;
      end
   end

   // row readout: one-cycle latency after the sampled read edge, data holds between reads
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         read_pend_q <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
      end else begin
         read_pend_q <= {read2_rise, read1_rise};
         valid_q     <= |read_pend_q;
         if (read_pend_q[0]) begin
            data_q <= {code_q[1], code_q[0]};
         end else if (read_pend_q[1]) begin
            data_q <= {code_q[3], code_q[2]};
         end
      end
   end

   // sticky protocol error on overlapping phases
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (multi_phase) begin
         err_q <= 1'b1;
      end
   end

   assign bus.data_out     = data_q;
   assign bus.data_valid   = valid_q;
   assign bus.overflow     = overflow_q;
   assign bus.code_cnt     = cnt_q;
   assign bus.protocol_err = err_q;
endmodule

// File: tb/tb_pixel_readout.sv
// tb/tb_pixel_readout.sv - directed and randomized check of pixel_readout against a phase-level model
module tb_pixel_readout;
   localparam int BITS  = 8;
   localparam int N_PIX = 4;
   localparam int NEVER = 100000;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   pixel_readout_if #(.BITS(BITS), .N_PIX(N_PIX)) bus ();

   pixel_readout #(.BITS(BITS), .N_PIX(N_PIX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endfunction

   // phase-level model: phase 0 idle, 1 erase, 2 expose, 3 convert, 4 read1, 5 read2
   bit [7:0]  m_code [4];
   bit        m_fired [4];
   int        m_cnt;
   bit [3:0]  m_ovf;
   bit        m_err;
   bit [15:0] m_dout;
   bit        m_dv;
   int        m_prev;
   int        m_req;

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         m_code[i]  = 8'h00;
         m_fired[i] = 1'b0;
      end
      m_cnt  = 0;
      m_ovf  = 4'b0000;
      m_err  = 1'b0;
      m_dout = 16'h0000;
      m_dv   = 1'b0;
      m_prev = 0;
      m_req  = 0;
   endtask

   always @(posedge clk) begin : model_p
      int ph;
      int nhigh;
      if (reset) begin
         model_clear();
      end else begin
         nhigh = int'(bus.erase) + int'(bus.expose) + int'(bus.convert) + int'(bus.read1) + int'(bus.read2);
         if (nhigh > 1) m_err = 1'b1;
         ph = bus.erase ? 1 : bus.convert ? 3 : bus.read1 ? 4 : bus.read2 ? 5 : bus.expose ? 2 : 0;
         m_dv = (m_req != 0);
         if (m_req == 1) m_dout = {m_code[1], m_code[0]};
         else if (m_req == 2) m_dout = {m_code[3], m_code[2]};
         m_req = 0;
         if (ph == 1) begin
            for (int i = 0; i < 4; i++) begin
               m_code[i]  = 8'h00;
               m_fired[i] = 1'b0;
            end
            m_ovf = 4'b0000;
            m_cnt = 0;
         end else if (ph == 3) begin
            for (int i = 0; i < 4; i++) begin
               if (!m_fired[i] && bus.cmp[i]) begin
                  m_code[i]  = 8'(m_cnt);
                  m_fired[i] = 1'b1;
               end
            end
            if (m_cnt < 255) m_cnt++;
         end else begin
            if (m_prev == 3) begin
               for (int i = 0; i < 4; i++) begin
                  if (!m_fired[i]) begin
                     m_code[i] = 8'hFF;
                     m_ovf[i]  = 1'b1;
                  end else begin
                     m_ovf[i]  = 1'b0;
                  end
               end
               m_cnt = 0;
            end
            if (ph == 4 && m_prev != 4) m_req = 1;
            if (ph == 5 && m_prev != 5) m_req = 2;
         end
         m_prev = ph;
      end
      #1;
      check("cmp_data_out", 32'(bus.data_out), 32'(m_dout));
      check("cmp_data_valid", 32'(bus.data_valid), 32'(m_dv));
      check("cmp_overflow", 32'(bus.overflow), 32'(m_ovf));
      check("cmp_code_cnt", 32'(bus.code_cnt), 32'(m_cnt));
      check("cmp_protocol_err", 32'(bus.protocol_err), 32'(m_err));
   end

   task automatic phases_off();
      bus.erase   = 1'b0;
      bus.expose  = 1'b0;
      bus.convert = 1'b0;
      bus.read1   = 1'b0;
      bus.read2   = 1'b0;
   endtask

   task automatic pulse_erase();
      @(negedge clk);
      bus.erase = 1'b1;
      @(negedge clk);
      bus.erase = 1'b0;
   endtask

   // convert for n cycles; in cycle k (code_cnt == k while unsaturated) cmp[i] = (k >= rise_i)
   task automatic run_convert(input int n, input int r0, input int r1, input int r2, input int r3);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         bus.convert = 1'b1;
         bus.cmp     = {k >= r3, k >= r2, k >= r1, k >= r0};
         @(posedge clk);
      end
      @(negedge clk);
      bus.convert = 1'b0;
      bus.cmp     = '0;
   endtask

   task automatic do_read(input int row, input int len, output logic [15:0] d,
                          output int pulses, output int first);
      pulses = 0;
      first  = -1;
      d      = 16'h0000;
      for (int c = 0; c < len + 3; c++) begin
         @(negedge clk);
         if (row == 1) bus.read1 = (c < len);
         else          bus.read2 = (c < len);
         @(posedge clk);
         #1;
         if (bus.data_valid) begin
            if (first < 0) first = c;
            pulses++;
            d = bus.data_out;
         end
      end
   endtask

   initial begin
      logic [15:0] d;
      int          pulses;
      int          first;
      logic [4:0]  ph;
      int          sel;
      int          len;

      phases_off();
      bus.cmp = '0;
      reset   = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("reset_data_out", 32'(bus.data_out), 32'h0);
      check("reset_overflow", 32'(bus.overflow), 32'h0);
      check("reset_err", 32'(bus.protocol_err), 32'h0);

      // read with no convert returns zero codes
      do_read(1, 1, d, pulses, first);
      check("noconv_read1", 32'(d), 32'h0000);

      // capture and read of both rows
      pulse_erase();
      run_convert(256, 10, 200, 0, NEVER);
      do_read(1, 1, d, pulses, first);
      check("t2_read1", 32'(d), 32'hC80A);
      do_read(2, 1, d, pulses, first);
      check("t2_read2", 32'(d), 32'hFF00);
      check("t2_overflow", 32'(bus.overflow), 32'b1000);

      // glitching comparator keeps its first code; long read gives one strobe
      pulse_erase();
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         bus.convert = 1'b1;
         bus.cmp     = {3'b000, (k == 10) || (k >= 50)};
         @(posedge clk);
      end
      @(negedge clk);
      bus.convert = 1'b0;
      bus.cmp     = '0;
      do_read(1, 5, d, pulses, first);
      check("t3_code0", 32'(d[7:0]), 32'd10);
      check("t4_pulses", 32'(pulses), 32'd1);
      check("t4_latency", 32'(first), 32'd1);

      // saturation: late firing pixel reads all ones without overflow
      pulse_erase();
      run_convert(300, NEVER, 280, NEVER, NEVER);
      check("t5_cnt_sat", 32'(bus.code_cnt), 32'd255);
      do_read(1, 2, d, pulses, first);
      check("t5_read1", 32'(d), 32'hFFFF);
      check("t5_overflow", 32'(bus.overflow), 32'b1101);

      // convert re-entered without erase: only unfired pixels capture, counter restarts
      run_convert(20, 5, 0, NEVER, NEVER);
      do_read(1, 1, d, pulses, first);
      check("reenter_read1", 32'(d), 32'hFF05);
      check("reenter_overflow", 32'(bus.overflow), 32'b1100);

      // erase and convert together: erase wins, error is sticky
      @(negedge clk);
      bus.erase   = 1'b1;
      bus.convert = 1'b1;
      @(negedge clk);
      phases_off();
      check("t6_err", 32'(bus.protocol_err), 32'd1);
      do_read(1, 1, d, pulses, first);
      check("t6_cleared", 32'(d), 32'h0000);
      check("t6_err_sticky", 32'(bus.protocol_err), 32'd1);

      // asynchronous reset mid-convert, then convert continues as a fresh one
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         bus.convert = 1'b1;
         @(posedge clk);
      end
      #3;
      reset = 1'b1;
      #1;
      check("t1_async_cnt", 32'(bus.code_cnt), 32'd0);
      check("t1_async_err", 32'(bus.protocol_err), 32'd0);
      check("t1_async_data", 32'(bus.data_out), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset   = 1'b0;
      bus.cmp = 4'b0010;
      repeat (5) @(negedge clk);
      bus.convert = 1'b0;
      bus.cmp     = '0;
      do_read(1, 1, d, pulses, first);
      check("t6_after_reset", 32'(d), 32'h00FF);

      // randomized phase sequences with occasional overlap and reset
      for (int s = 0; s < 70; s++) begin
         sel = $urandom_range(0, 5);
         len = (sel == 3) ? $urandom_range(1, 300) : $urandom_range(1, 6);
         for (int c = 0; c < len; c++) begin
            @(negedge clk);
            ph = 5'b00000;
            if (sel > 0) ph[sel-1] = 1'b1;
            if ($urandom_range(0, 99) == 0) ph[$urandom_range(0, 4)] = 1'b1;
            {bus.read2, bus.read1, bus.convert, bus.expose, bus.erase} = ph;
            for (int i = 0; i < N_PIX; i++) bus.cmp[i] = ($urandom_range(0, 31) == 0);
         end
         if ($urandom_range(0, 29) == 0) begin
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end
      end
      @(negedge clk);
      phases_off();
      bus.cmp = '0;
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
